seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
- Parametrised, multi-cycle successor to the 64-bit combinational adder (65-bit sum).
- Adds or subtracts two WIDTH-bit unsigned operands one CHUNK-bit slice per clock, rippling carry/borrow through a register between slices.
- Has valid/ready handshakes on input and output, and an add/sub mode bit.
- Sits in the datapath wherever a wide adder would otherwise break timing; trades latency for a CHUNK-bit critical path.

Parameters:
- WIDTH, 64, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 16, slice width processed per cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands and mode present
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A (unsigned)
- b  in  WIDTH  operand B (unsigned)
- sub  in  1  0: a+b, 1: a-b
- out_valid  out  1  sout is valid
- out_ready  in  1  consumer accepts sout
- sout  out  WIDTH+1  result; bit WIDTH is carry (add) or borrow (sub)
- busy  out  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock domain; rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sout=0, chunk index=0, carry register=0.
- NCHUNK = WIDTH/CHUNK.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a, b and sub.
  - When sub=1, latch ~b and preset the carry register to 1; when sub=0, latch b and preset the carry to 0.
  - Clear the chunk index, then go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, slice k = bits [k*CHUNK +: CHUNK] is summed with the carry register.
  - The sum is written into sout[k*CHUNK +: CHUNK] and the carry-out is stored back into the carry register.
  - k increments each cycle.
  - When k=NCHUNK-1, also write sout[WIDTH] and go to DONE:
    - sub=0: sout[WIDTH] = carry-out.
    - sub=1: sout[WIDTH] = ~carry-out, i.e. 1 iff a<b.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge (4 cycles at the defaults).
- DONE:
  - out_valid=1, and sout is held stable until out_valid&&out_ready.
  - On out_valid&&out_ready, go to IDLE with out_valid=0.
  - in_ready returns one cycle later; there is no same-cycle accept-on-drain.
  - Back-to-back throughput is therefore one operation per NCHUNK+2 cycles.
- Input changes while not in IDLE are ignored; the latched operands are used.
- Backpressure: out_ready low holds DONE indefinitely with all outputs unchanged.
- Reset mid-operation, in RUN or DONE: the next cycle is the reset state and any partial result is discarded. sout reads 0, not stale data.
- CHUNK=WIDTH degenerates to 1-cycle RUN; must still obey the same handshake.
- Arithmetic:
  - add: sout = a+b exactly, in WIDTH+1 bits.
  - sub: sout[WIDTH-1:0] = (a-b) mod 2^WIDTH, sout[WIDTH] = borrow.
- Parameter check: elaboration-time error if WIDTH % CHUNK != 0.

Decomposition:
- Package seq_chunk_adder_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function computing NCHUNK;
  - a function computing the chunk-index width, clog2(NCHUNK) with a minimum of 1.
- One combinational sub-module, chunk_adder (CHUNK-bit adder with cin/cout), is instantiated once.
- The FSM, operand registers and result register live in the top module.

Test Plan:
- add a=64'd18446744073709551614, b=64'd1 -> after 4 cycles out_valid=1, sout=65'h0_FFFF_FFFF_FFFF_FFFF.
- add a=b=64'hFFFF_FFFF_FFFF_FFFF -> sout=65'h1_FFFF_FFFF_FFFF_FFFE; also a=184, b=1256 -> sout=1440, and a=156596564, b=125556 -> 156722120.
- sub a=14, b=7 -> sout=7, bit64=0; sub a=7, b=14 -> sout[63:0]=64'hFFFF_FFFF_FFFF_FFF9, bit64=1.
- Hold out_ready=0 for 10 cycles after out_valid -> sout and out_valid stable, in_ready=0; after one out_ready pulse, in_ready=1 on the following cycle.
- Assert rst for one cycle at the second RUN cycle of a=8446744073709551614, b=10000000000000000000 -> next cycle IDLE, in_ready=1, out_valid=0, sout=0.
- Reissue the same operands -> sout=18446744073709551614 with bit64=0.
- Re-run all vectors at CHUNK=64, 8 and 1 (and WIDTH=32, CHUNK=8) -> identical results with latency NCHUNK.

Source files
------------

// File: rtl/seq_chunk_adder_pkg.sv
// ============================================================================
//  Module      : seq_chunk_adder_pkg
//  Description : Shared state encoding and sizing helpers for seq_chunk_adder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_chunk_adder_chunk_adder.sv
// ============================================================================
//  Module      : chunk_adder
//  Description : CHUNK-bit combinational adder with carry in and carry out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunk_adder #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

`default_nettype wire

// File: rtl/seq_chunk_adder.sv
// ============================================================================
//  Module      : seq_chunk_adder
//  Description : Multi-cycle WIDTH-bit add/sub, one CHUNK-bit slice per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sout,
    output logic             busy
);

    localparam int                 c_nchunk   = calc_nchunk(WIDTH, CHUNK);
    localparam int                 c_idx_w    = calc_idx_w(c_nchunk);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nchunk - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
            $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sub;
    logic               r_carry;
    logic [c_idx_w-1:0] r_idx;
    logic [WIDTH:0]     r_sout;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [31:0]        w_base;
    logic [CHUNK-1:0]   w_a_slice;
    logic [CHUNK-1:0]   w_b_slice;
    logic [CHUNK-1:0]   w_sum;
    logic               w_cout;

    assign w_base    = 32'(r_idx) * 32'(CHUNK);
    assign w_a_slice = r_a[w_base +: CHUNK];
    assign w_b_slice = r_b[w_base +: CHUNK];

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (w_a_slice),
        .b    (w_b_slice),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sout      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        // Subtraction is a + ~b + 1: invert b here and seed the carry.
                        r_a        <= a;
                        r_b        <= sub ? ~b : b;
                        r_sub      <= sub;
                        r_carry    <= sub;
                        r_idx      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    r_sout[w_base +: CHUNK] <= w_sum;
                    r_carry                 <= w_cout;
                    r_idx                   <= r_idx + 1'b1;
                    if (r_idx == c_last_idx) begin
                        // Final carry-out of a + ~b + 1 is the inverse of the borrow.
                        r_sout[WIDTH] <= w_cout ^ r_sub;
                        r_state       <= DONE;
                        r_out_valid   <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sout      = r_sout;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
// ============================================================================
//  Module      : tb_seq_chunk_adder
//  Description : Scoreboard bench driving five adder configurations in lockstep.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_chunk_adder;

    localparam int c_ndut = 5;

    function automatic int cfg_w(input int i);
        return (i == 4) ? 32 : 64;
    endfunction

    function automatic int cfg_c(input int i);
        case (i)
            0:       return 16;
            1:       return 64;
            2:       return 8;
            3:       return 1;
            default: return 8;
        endcase
    endfunction

    typedef struct {
        logic [64:0] e [c_ndut];
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [63:0]       a;
    logic [63:0]       b;
    logic              sub;
    logic              out_ready;
    logic [c_ndut-1:0] rdy;
    logic [c_ndut-1:0] ov;
    logic [c_ndut-1:0] bsy;
    logic [64:0]       sout_arr [c_ndut];

    exp_t q [$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < c_ndut; g++) begin : g_dut
            localparam int W = cfg_w(g);
            localparam int C = cfg_c(g);
            logic [W:0] s;
            seq_chunk_adder #(
                .WIDTH (W),
                .CHUNK (C)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (rdy[g]),
                .a         (a[W-1:0]),
                .b         (b[W-1:0]),
                .sub       (sub),
                .out_valid (ov[g]),
                .out_ready (out_ready),
                .sout      (s),
                .busy      (bsy[g])
            );
            assign sout_arr[g] = 65'(s);
        end
    endgenerate

    function automatic logic [64:0] model(input logic [63:0] x, input logic [63:0] y,
                                          input logic s, input int w);
        logic [64:0] xa;
        logic [64:0] ya;
        logic [64:0] r;
        if (w == 32) begin
            xa = {33'b0, x[31:0]};
            ya = {33'b0, y[31:0]};
        end else begin
            xa = {1'b0, x};
            ya = {1'b0, y};
        end
        r = s ? (xa - ya) : (xa + ya);
        if (w == 32) r = {32'b0, r[32:0]};
        return r;
    endfunction

    task automatic check_idle_state(input string tag);
        for (int g = 0; g < c_ndut; g++) begin
            n_vec++;
            if ({rdy[g], ov[g], bsy[g]} !== 3'b100) begin
                n_err++;
                $display("FAIL %s dut%0d: rdy/ov/busy got %b required 100", tag, g,
                         {rdy[g], ov[g], bsy[g]});
            end
            n_vec++;
            if (sout_arr[g] !== 65'd0) begin
                n_err++;
                $display("FAIL %s dut%0d: sout got %h required 0", tag, g, sout_arr[g]);
            end
        end
    endtask

    task automatic run_op(input logic [63:0] ia, input logic [63:0] ib, input logic isub,
                          input int hold);
        exp_t ex;
        int   lat [c_ndut];
        int   n;
        bit   all;
        n = 0;
        @(negedge clk);
        while (rdy !== {c_ndut{1'b1}} && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (rdy !== {c_ndut{1'b1}}) begin
            n_err++;
            $display("FAIL in_ready_wait: got %b required all ones", rdy);
        end
        in_valid = 1'b1;
        a = ia;
        b = ib;
        sub = isub;
        for (int g = 0; g < c_ndut; g++) begin
            ex.e[g] = model(ia, ib, isub, cfg_w(g));
            lat[g] = -1;
        end
        q.push_back(ex);
        @(negedge clk);
        // Scramble inputs while busy: the latched copy must be used.
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        sub = ~isub;
        n = 0;
        all = 1'b0;
        while (!all && n < 200) begin
            @(negedge clk);
            n++;
            all = 1'b1;
            for (int g = 0; g < c_ndut; g++) begin
                if (ov[g] && lat[g] < 0) lat[g] = n;
                if (lat[g] < 0) all = 1'b0;
            end
        end
        ex = q.pop_front();
        for (int g = 0; g < c_ndut; g++) begin
            n_vec++;
            if (lat[g] != cfg_w(g) / cfg_c(g)) begin
                n_err++;
                $display("FAIL latency dut%0d: got %0d required %0d", g, lat[g],
                         cfg_w(g) / cfg_c(g));
            end
            n_vec++;
            if (sout_arr[g] !== ex.e[g]) begin
                n_err++;
                $display("FAIL sout dut%0d a=%h b=%h sub=%b: got %h required %h", g, ia, ib,
                         isub, sout_arr[g], ex.e[g]);
            end
            n_vec++;
            if (bsy[g] !== 1'b1 || rdy[g] !== 1'b0) begin
                n_err++;
                $display("FAIL done_flags dut%0d: busy/rdy got %b%b required 10", g, bsy[g],
                         rdy[g]);
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            for (int g = 0; g < c_ndut; g++) begin
                n_vec++;
                if (ov[g] !== 1'b1 || rdy[g] !== 1'b0 || sout_arr[g] !== ex.e[g]) begin
                    n_err++;
                    $display("FAIL hold dut%0d cyc%0d: ov=%b rdy=%b sout=%h required 1 0 %h",
                             g, h, ov[g], rdy[g], sout_arr[g], ex.e[g]);
                end
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int g = 0; g < c_ndut; g++) begin
            n_vec++;
            if (ov[g] !== 1'b0 || rdy[g] !== 1'b1 || bsy[g] !== 1'b0) begin
                n_err++;
                $display("FAIL drain dut%0d: ov/rdy/busy got %b%b%b required 010", g, ov[g],
                         rdy[g], bsy[g]);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_state("reset");
    endtask

    task automatic test_add;
        run_op(64'd18446744073709551614, 64'd1, 1'b0, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        run_op(64'd184, 64'd1256, 1'b0, 0);
        run_op(64'd156596564, 64'd125556, 1'b0, 0);
    endtask

    task automatic test_sub;
        run_op(64'd14, 64'd7, 1'b1, 0);
        run_op(64'd7, 64'd14, 1'b1, 0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 0);
        run_op(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
    endtask

    task automatic test_backpressure;
        run_op(64'hDEAD_BEEF_0000_FFFF, 64'h0123_4567_FFFF_0001, 1'b0, 10);
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        in_valid = 1'b1;
        a = 64'd8446744073709551614;
        b = 64'd10000000000000000000;
        sub = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_state("mid_reset");
        run_op(64'd8446744073709551614, 64'd10000000000000000000, 1'b0, 0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'(i & 1), 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
